// File: rtl/mask_gen_pkg.sv
// Shared types and constants for the VGA row-mask generator.
package mask_gen_pkg;

  localparam int MASK_W    = 640;
  localparam int PAT_W     = 32;
  localparam int RP_W      = 8;
  localparam int RP_IDX_W  = $clog2(RP_W);

  // Fibonacci taps 32,22,2,1 expressed as state bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    SLIDE_R = 2'b00,
    SLIDE_L = 2'b01,
    RANDOM  = 2'b10,
    REPEAT  = 2'b11
  } mask_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

  // Out-of-range tile widths fall back to the full repeated-pattern register.
  function automatic logic [3:0] tile_width(input logic [4:0] w);
    if (w == 5'd0 || w > 5'(RP_W)) return 4'(RP_W);
    return w[3:0];
  endfunction

endpackage

// File: rtl/mask_generation_vga_if.sv
// Configuration-side inputs and mask-side outputs of the row-mask generator.
interface mask_generation_vga_if;
  import mask_gen_pkg::*;

  logic                clk_en;
  logic [4:0]          pattern_w;
  logic                pattern;
  logic [RP_W-1:0]     repeatedPattern;
  logic                load_pattern;
  logic [1:0]          mask_type;
  logic [0:MASK_W-1]   mg_mask;
  logic                rp_valid;

  modport master (
    output clk_en, pattern_w, pattern, repeatedPattern, load_pattern, mask_type,
    input  mg_mask, rp_valid
  );

  modport slave (
    input  clk_en, pattern_w, pattern, repeatedPattern, load_pattern, mask_type,
    output mg_mask, rp_valid
  );

endinterface

// File: rtl/mask_lfsr32.sv
// 32-bit Fibonacci LFSR with synchronous seed load and step enable.
module mask_lfsr32
  import mask_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)       r_state <= '0;
    else if (i_load) r_state <= i_seed;
    else if (i_step) r_state <= lfsr_step(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/mask_generation_vga.sv
// VGA per-row mask generator: serial pattern load, then slide/random/tiled rows.
module mask_generation_vga
  import mask_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mask_generation_vga_if.slave mg_if
);

  state_e            r_state, w_state_nxt;
  mask_type_e        r_mode, w_mode_nxt;
  logic [0:PAT_W-1]  r_pat_reg, w_pat_nxt;
  logic [0:MASK_W-1] r_mask, w_mask_nxt, w_rep_mask;
  logic              r_rp_valid, w_valid_nxt;
  logic              w_seed_en, w_step;
  logic [31:0]       w_lfsr_seed, w_lfsr_state;
  logic [3:0]        w_tile_n;

  assign w_lfsr_seed = (r_pat_reg == '0) ? 32'h1 : r_pat_reg;

  mask_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_seed_en & mg_if.clk_en),
    .i_seed  (w_lfsr_seed),
    .i_step  (w_step & mg_if.clk_en),
    .o_state (w_lfsr_state)
  );

  always_comb begin
    w_tile_n = tile_width(mg_if.pattern_w);
    for (int i = 0; i < MASK_W; i++)
      w_rep_mask[i] = mg_if.repeatedPattern[RP_IDX_W'(i % int'(w_tile_n))];
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_pat_nxt   = r_pat_reg;
    w_mask_nxt  = r_mask;
    w_valid_nxt = 1'b0;
    w_seed_en   = 1'b0;
    w_step      = 1'b0;
    if (mg_if.load_pattern) begin
      w_state_nxt = S_LOAD;
      w_pat_nxt   = {mg_if.pattern, r_pat_reg[0:PAT_W-2]};
    end else begin
      case (r_state)
        S_LOAD: begin
          w_state_nxt = S_RUN;
          w_mode_nxt  = mask_type_e'(mg_if.mask_type);
          case (w_mode_nxt)
            SLIDE_R, SLIDE_L: w_mask_nxt = {r_pat_reg, {(MASK_W-PAT_W){1'b0}}};
            RANDOM:           w_seed_en  = 1'b1;
            default:          ;
          endcase
        end
        S_RUN: begin
          w_valid_nxt = 1'b1;
          case (r_mode)
            SLIDE_R: w_mask_nxt = {r_mask[MASK_W-1], r_mask[0:MASK_W-2]};
            SLIDE_L: w_mask_nxt = {r_mask[1:MASK_W-1], r_mask[0]};
            RANDOM: begin
              w_step     = 1'b1;
              w_mask_nxt = {(MASK_W/32){lfsr_step(w_lfsr_state)}};
            end
            default: begin
              w_mask_nxt  = w_rep_mask;
              w_state_nxt = S_IDLE;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // rst_n is active-high here despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= SLIDE_R;
      r_pat_reg  <= '0;
      r_mask     <= '0;
      r_rp_valid <= 1'b0;
    end else if (mg_if.clk_en) begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_pat_reg  <= w_pat_nxt;
      r_mask     <= w_mask_nxt;
      r_rp_valid <= w_valid_nxt;
    end else begin
      r_rp_valid <= 1'b0;
    end
  end

  // Gating keeps a stalled cycle from re-presenting an already-consumed row.
  assign mg_if.mg_mask  = r_mask;
  assign mg_if.rp_valid = r_rp_valid & mg_if.clk_en;

endmodule

// File: tb/tb_mask_generation_vga.sv
// Directed bench for mask_generation_vga covering all four mask modes.
module tb_mask_generation_vga;
  import mask_gen_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mask_generation_vga_if mg_if ();

  mask_generation_vga dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mg_if (mg_if)
  );

  // Expected rows are held MSB-first: bit 639 is pixel index 0.
  task automatic check(input string tag, input logic [MASK_W-1:0] got,
                       input logic [MASK_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MASK_W-1:0] rot_r(input logic [MASK_W-1:0] v, input int k);
    return (v >> k) | (v << (MASK_W - k));
  endfunction

  function automatic logic [MASK_W-1:0] rot_l(input logic [MASK_W-1:0] v, input int k);
    return (v << k) | (v >> (MASK_W - k));
  endfunction

  // Bit 0 goes in first so the value reads MSB-first from pixel 0.
  task automatic load_bits(input logic [31:0] v, input logic [1:0] mt);
    for (int k = 0; k < 32; k++) begin
      mg_if.load_pattern = 1'b1;
      mg_if.pattern      = v[k];
      mg_if.mask_type    = mt;
      step();
      check("load_valid_low", mg_if.rp_valid, 1'b0);
    end
    mg_if.load_pattern = 1'b0;
    mg_if.pattern      = 1'b0;
  endtask

  task automatic run_rep(input logic [4:0] pw, input logic [7:0] rp,
                         input logic [MASK_W-1:0] exp, input string tag);
    mg_if.load_pattern    = 1'b1;
    mg_if.mask_type       = 2'b11;
    mg_if.pattern_w       = pw;
    mg_if.repeatedPattern = rp;
    step();
    check({tag, "_load"}, mg_if.rp_valid, 1'b0);
    mg_if.load_pattern = 1'b0;
    step();
    check({tag, "_lat"}, mg_if.rp_valid, 1'b0);
    step();
    check({tag, "_valid"}, mg_if.rp_valid, 1'b1);
    check({tag, "_row"}, mg_if.mg_mask, exp);
    step();
    check({tag, "_once"}, mg_if.rp_valid, 1'b0);
    step();
    check({tag, "_idle"}, mg_if.rp_valid, 1'b0);
  endtask

  initial begin
    logic [MASK_W-1:0] init0, init1, held;
    logic [31:0]       s;

    mg_if.clk_en          = 1'b1;
    mg_if.load_pattern    = 1'b0;
    mg_if.pattern         = 1'b0;
    mg_if.pattern_w       = 5'd0;
    mg_if.repeatedPattern = 8'h00;
    mg_if.mask_type       = 2'b00;
    step();
    step();
    check("reset_mask", mg_if.mg_mask, '0);
    check("reset_valid", mg_if.rp_valid, 1'b0);
    rst_n = 1'b0;
    step();

    // Slide right with a mid-run stall; mask_type change in RUN is ignored.
    init0 = {32'h03D0A052, 608'b0};
    load_bits(32'h03D0A052, 2'b00);
    step();
    check("m00_latency", mg_if.rp_valid, 1'b0);
    check("m00_preload", mg_if.mg_mask, init0);
    mg_if.mask_type = 2'b11;
    for (int k = 1; k <= MASK_W; k++) begin
      step();
      check("m00_valid", mg_if.rp_valid, 1'b1);
      check("m00_row", mg_if.mg_mask, rot_r(init0, k));
      if (k == 100) begin
        held = rot_r(init0, k);
        mg_if.clk_en = 1'b0;
        #1;
        check("stall_valid_now", mg_if.rp_valid, 1'b0);
        for (int p = 0; p < 5; p++) begin
          step();
          check("stall_valid", mg_if.rp_valid, 1'b0);
          check("stall_mask", mg_if.mg_mask, held);
        end
        mg_if.clk_en = 1'b1;
      end
    end
    check("m00_period", mg_if.mg_mask, init0);

    // Load issued while still running mode 00 aborts it.
    init1 = {32'h80000001, 608'b0};
    load_bits(32'h80000001, 2'b01);
    step();
    check("m01_latency", mg_if.rp_valid, 1'b0);
    check("m01_preload", mg_if.mg_mask, init1);
    for (int k = 1; k <= MASK_W; k++) begin
      step();
      check("m01_valid", mg_if.rp_valid, 1'b1);
      check("m01_row", mg_if.mg_mask, rot_l(init1, k));
      if (k == 1) begin
        check("m01_bit0", mg_if.mg_mask[0], 1'b0);
        check("m01_bit30", mg_if.mg_mask[30], 1'b1);
        check("m01_bit31", mg_if.mg_mask[31], 1'b0);
        check("m01_bit639", mg_if.mg_mask[639], 1'b1);
      end
    end
    check("m01_period", mg_if.mg_mask, init1);

    run_rep(5'd4,  8'b10101111, {MASK_W{1'b1}},           "m11_w4");
    run_rep(5'd3,  8'b00000110, {{213{3'b011}}, 1'b0},    "m11_w3");
    run_rep(5'd0,  8'hA5,       {80{8'b10100101}},        "m11_w0");
    run_rep(5'd12, 8'h0F,       {80{8'b11110000}},        "m11_w12");

    load_bits(32'h0, 2'b10);
    step();
    check("m10_latency", mg_if.rp_valid, 1'b0);
    s = 32'h1;
    for (int k = 1; k <= 481; k++) begin
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
      step();
      check("m10_valid", mg_if.rp_valid, 1'b1);
      check("m10_row", mg_if.mg_mask, {20{s}});
    end

    rst_n = 1'b1;
    #1;
    check("async_rst_mask", mg_if.mg_mask, '0);
    check("async_rst_valid", mg_if.rp_valid, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_valid", mg_if.rp_valid, 1'b0);
      check("post_rst_mask", mg_if.mg_mask, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mask_generation_vga.md
Name: mask_generation_vga

Overview:
- Generates one 640-bit per-row pixel mask for a 640x480 VGA frame, presenting one row per enabled clock.
- Four modes: sliding-right, sliding-left, pseudo-random and tiled repeated pattern.
- Sits between the pattern-configuration logic (serial pattern load) and the row-masking datapath.

Parameters:
- MASK_W, 640, mask row width in pixels.
- PAT_W, 32, serially loaded pattern length.
- RP_W, 8, repeated-pattern register width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. The polarity is counter to the _n suffix: asynchronous, active-high, asserted when 1. The port name follows codebase naming.
- clk_en  in  1  global enable. When 0, all state holds and rp_valid=0.
- pattern_w  in  5  repeated-mode tile width in bits; 0 or >8 means 8.
- pattern  in  1  serial pattern bit, sampled when load_pattern=1.
- repeatedPattern  in  RP_W  tile source for repeated mode; bit 0 is leftmost in the tile.
- load_pattern  in  1  load strobe.
- mask_type  in  2  00 slide right, 01 slide left, 10 random, 11 repeated.
- mg_mask  out  [0:MASK_W-1]  mask row; index 0 is the leftmost pixel.
- rp_valid  out  1  mg_mask holds a new valid row this cycle.

Behaviour:
- Reset clears mg_mask, rp_valid, pat_reg and LFSR, and puts the FSM in IDLE. Reset mid-operation aborts immediately.
- All actions below occur only when clk_en=1; when clk_en=0 everything holds.
- FSM states: IDLE, LOAD, RUN.
- load_pattern=1 in any state:
  - Go to LOAD and drive rp_valid=0.
  - pat_reg[0:31] shifts toward higher index: pat_reg[i]<=pat_reg[i-1], pat_reg[0]<=pattern.
  - After 32 loads, the first bit shifted in sits at pat_reg[31] and the last at pat_reg[0].
- LOAD and load_pattern=0: latch mask_type internally and go to RUN.
  - Modes 00/01: mg_mask <= {pat_reg, 608 zeros}.
  - Mode 10: LFSR seed <= pat_reg, or 32'h1 if pat_reg=0.
  - Mode 11: no preload.
- RUN, mode 00: each cycle mg_mask rotates right by one (new[i]=old[i-1], new[0]=old[639]); rp_valid=1. The first valid row is already rotated once; the 640th valid row equals the initial state.
- RUN, mode 01: rotate left by one (new[i]=old[i+1], new[639]=old[0]); rp_valid=1; same period as mode 00.
- RUN, mode 10:
  - Each cycle the LFSR advances one step: 32-bit Fibonacci, taps 32,22,2,1, shift in at LSB.
  - mg_mask = 20 copies of the new LFSR state, bit 31 leftmost; rp_valid=1.
  - Generation continues indefinitely; the consumer counts rows (480 per frame).
- RUN, mode 11:
  - N = pattern_w in 1..8, else 8.
  - mg_mask[i] = repeatedPattern[i mod N].
  - rp_valid=1 for exactly one cycle, then go to IDLE.
- A repeated-mode load is a single load_pattern cycle; pattern is ignored in that mode.
- Latency: first rp_valid occurs on the first rising edge after the edge that sees load_pattern=0, i.e. two cycles after the last load cycle.
- rp_valid is registered and coincident with the row it qualifies.
- A load during RUN aborts generation with no valid row that cycle.
- mask_type changes during RUN are ignored until the next load.

Decomposition:
- Package mask_gen_pkg holds:
  - typedef enum mask_type_e {SLIDE_R, SLIDE_L, RANDOM, REPEAT};
  - MASK_W, PAT_W, RP_W;
  - LFSR tap constant;
  - FSM state enum.
- Sub-module mask_lfsr32: seed load, step enable, 32-bit state output.
- Everything else is top-level.

Test Plan:
- Mode 00, 32 serial loads of 32'h03D0A052 -> mg_mask = 0x03D0A052 followed by 608 zeros, rotated right by one at the first valid. Each row is a 1-bit right rotation. Row 640 equals the initial state.
- Mode 01, pattern 32'h80000001 -> first valid row has bit 0 = 0, bit 31 set at index 30 and the wrapped bit at index 639. Row 640 equals the initial state.
- Mode 11, pattern_w=4, repeatedPattern=8'b10101111 -> one-cycle rp_valid two cycles after the load. mg_mask repeats "1111" (repeatedPattern bits 0..3) across 640 bits, then rp_valid stays 0.
- Mode 10, seed 32'h00000000 -> LFSR runs from 32'h1. After 481 valid rows the rows match the software LFSR model, each row being 20 copies of the state.
- clk_en=0 for 5 cycles mid-run in mode 00 -> mg_mask frozen, rp_valid=0; rotation resumes unchanged afterwards.
- Reset asserted mid-run -> mg_mask=0 and rp_valid=0 immediately (asynchronous). No output until a new load.
